// File: rtl/prog_interval_timer_pkg.sv
// -----------------------------------------------------------------------------
// prog_interval_timer_pkg
//   Shared definitions for the programmable interval timer: the FSM state
//   encoding and the one-shot / periodic mode encoding of the mode input.
// -----------------------------------------------------------------------------
package prog_interval_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage : prog_interval_timer_pkg

// File: rtl/prog_interval_timer_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//   Divides the clock by exactly TICK_DIV. While en is high the internal
//   counter advances once per clock and wraps to 0 after TICK_DIV-1; tick is
//   high during the cycle in which the counter sits at TICK_DIV-1 with en high.
//   While en is low the counter holds.
//
// Ports
//   clk   in  system clock (posedge)
//   rst   in  synchronous active-low reset, clears the counter
//   clr   in  synchronous clear back to 0 (wins over en)
//   en    in  count enable
//   tick  out one-cycle base tick (combinational from the counter and en)
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    assign tick = en && (pre_q == PRE_LAST);

    // Explicit wrap at TICK_DIV-1 so the period does not depend on 2^PRE_W.
    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule : tick_prescaler

// File: rtl/prog_interval_timer.sv
// -----------------------------------------------------------------------------
// prog_interval_timer
//   Programmable interval timer. A prescaler produces a base tick every
//   TICK_DIV clocks; a loadable down-counter counts load_val ticks and then
//   pulses timeout. One-shot mode returns to idle after the pulse, periodic
//   mode reloads and keeps running with no gap cycle. enable pauses a running
//   interval, abort stops it silently, and start in RUN restarts it.
//
// Ports
//   clk        in  system clock (posedge)
//   rst        in  synchronous active-low reset
//   start      in  pulse: load load_val and begin timing (ignored if load_val==0)
//   abort      in  pulse: stop timing without a timeout
//   enable     in  level: 0 freezes prescaler and counter while running
//   mode       in  0 = one-shot, 1 = periodic; sampled at start
//   load_val   in  tick count N; sampled at start
//   timeout    out one-cycle pulse when N ticks have elapsed (registered)
//   busy       out high while running, including paused (registered)
//   remaining  out ticks left in the current interval, 0 when idle
// -----------------------------------------------------------------------------
module prog_interval_timer
    import prog_interval_timer_pkg::*;
#(
    parameter int TICK_DIV = 5000000,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             enable,
    input  logic             mode,
    input  logic [CNT_W-1:0] load_val,
    output logic             timeout,
    output logic             busy,
    output logic [CNT_W-1:0] remaining
);

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [CNT_W-1:0] reload_q,  reload_d;
    logic             mode_q,    mode_d;
    logic             timeout_q, timeout_d;

    logic pre_clr;
    logic pre_en;
    logic tick;

    // The prescaler only runs in RUN; enable low pauses it in place.
    assign pre_en = (state_q == ST_RUN) && enable;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .en   (pre_en),
        .tick (tick)
    );

    // Priority: abort > start > tick. abort only acts in RUN, so an abort in
    // IDLE lets a simultaneous start through.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        mode_d    = mode_q;
        timeout_d = 1'b0;
        pre_clr   = 1'b0;

        if (abort && (state_q == ST_RUN)) begin
            state_d = ST_IDLE;
            count_d = '0;
            pre_clr = 1'b1;
        end else if (start && (load_val != '0)) begin
            state_d  = ST_RUN;
            count_d  = load_val;
            reload_d = load_val;
            mode_d   = mode;
            pre_clr  = 1'b1;
        end else if ((state_q == ST_RUN) && tick) begin
            // Compare at 1 before decrementing so the counter never wraps.
            if (count_q == CNT_W'(1)) begin
                timeout_d = 1'b1;
                if (mode_q == MODE_PERIODIC) begin
                    // Prescaler wraps on its own, so the next interval
                    // starts immediately.
                    count_d = reload_q;
                end else begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    pre_clr = 1'b1;
                end
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            mode_q    <= MODE_ONESHOT;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            mode_q    <= mode_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout   = timeout_q;
    assign busy      = (state_q == ST_RUN);
    assign remaining = count_q;

endmodule : prog_interval_timer
